// File: rtl/cpu_pkg.sv
// Shared opcode map, FSM state encoding and instruction-width helper for the accumulator CPU.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package cpu_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDI = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_AND = 4'h4;
    localparam logic [3:0] OP_OR  = 4'h5;
    localparam logic [3:0] OP_XOR = 4'h6;
    localparam logic [3:0] OP_JMP = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_JC  = 4'h9;
    localparam logic [3:0] OP_OUT = 4'hA;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    // Instruction is a 4-bit opcode on top of a DATA_W-bit operand.
    function automatic int instr_w_of(input int data_w);
        return 4 + data_w;
    endfunction

endpackage

// File: rtl/param_alu.sv
// Combinational ALU for the accumulator CPU: LDI/ADD/SUB/AND/OR/XOR producing result, carry, zero.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides whether the result is written.
module param_alu
    import cpu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic              carry,
    output logic              zero
);

    logic [DATA_W:0] sum;
    logic [DATA_W:0] diff;

    // Widened add/sub so the top bit is carry-out / borrow respectively.
    always_comb begin
        sum  = {1'b0, a} + {1'b0, b};
        diff = {1'b0, a} - {1'b0, b};
    end

    // Result select; logic ops and LDI always clear carry.
    always_comb begin
        result = a;
        carry  = 1'b0;
        case (op)
            OP_LDI: result = b;
            OP_ADD: begin
                result = sum[DATA_W-1:0];
                carry  = sum[DATA_W];
            end
            OP_SUB: begin
                result = diff[DATA_W-1:0];
                carry  = diff[DATA_W];
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            default: begin
                result = a;
                carry  = 1'b0;
            end
        endcase
        zero = (result == '0);
    end

endmodule

// File: rtl/param_acc_cpu.sv
// Parameterised accumulator CPU: FETCH/EXEC/HALT sequencer around a combinational ALU.
// Latency: 2 cycles per instruction minimum (FETCH with immediate ack, then EXEC).
// Backpressure: imem_req and imem_addr are held stable in FETCH for any number of cycles until imem_ack.
module param_acc_cpu
    import cpu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    localparam int INSTR_W = instr_w_of(DATA_W)
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_valid,
    output logic [DATA_W-1:0]  acc_out,
    output logic [1:0]         flags_out,
    output logic               halted,
    output logic               illegal
);

    // ADDR_W must not exceed DATA_W: jump targets are taken from the operand field.

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q;
    logic [INSTR_W-1:0]  ir_q;
    logic [DATA_W-1:0]   acc_q;
    logic                carry_q, zero_q;
    logic [DATA_W-1:0]   out_data_q;
    logic                out_valid_q;
    logic                illegal_q;

    logic [3:0]          opcode;
    logic [DATA_W-1:0]   operand;
    logic [ADDR_W-1:0]   target;
    logic [ADDR_W-1:0]   pc_next;
    logic                jump_taken;
    logic                alu_wr;
    logic                undef_op;
    logic [DATA_W-1:0]   alu_result;
    logic                alu_carry, alu_zero;

    assign opcode  = ir_q[INSTR_W-1 -: 4];
    assign operand = ir_q[DATA_W-1:0];
    assign target  = operand[ADDR_W-1:0];

    param_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .op     (opcode),
        .a      (acc_q),
        .b      (operand),
        .result (alu_result),
        .carry  (alu_carry),
        .zero   (alu_zero)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and fetch request; HALT is left only through reset.
    always_comb begin
        state_d  = state_q;
        imem_req = 1'b0;
        case (state_q)
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) state_d = ST_EXEC;
            end
            ST_EXEC: state_d = (opcode == OP_HLT) ? ST_HALT : ST_FETCH;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_FETCH;
        endcase
    end

    // Decode: which ops write acc/flags, jump resolution against flags as registered at EXEC entry.
    always_comb begin
        alu_wr     = 1'b0;
        undef_op   = 1'b0;
        jump_taken = 1'b0;
        case (opcode)
            OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: alu_wr = 1'b1;
            OP_JMP: jump_taken = 1'b1;
            OP_JZ:  jump_taken = zero_q;
            OP_JC:  jump_taken = carry_q;
            OP_NOP, OP_OUT, OP_HLT: ;
            default: undef_op = 1'b1;
        endcase
        pc_next = jump_taken ? target : pc_q + ADDR_W'(1);
    end

    // Datapath: instruction capture in FETCH, architectural updates in EXEC.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q        <= '0;
            ir_q        <= '0;
            acc_q       <= '0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            if (state_q == ST_FETCH && imem_ack) begin
                ir_q <= imem_rdata;
            end
            if (state_q == ST_EXEC) begin
                if (alu_wr) begin
                    acc_q   <= alu_result;
                    carry_q <= alu_carry;
                    zero_q  <= alu_zero;
                end
                if (opcode == OP_OUT) begin
                    out_data_q  <= acc_q;
                    out_valid_q <= 1'b1;
                end
                if (undef_op) begin
                    illegal_q <= 1'b1;
                end
                if (opcode != OP_HLT) begin
                    pc_q <= pc_next;
                end
            end
        end
    end

    assign imem_addr = pc_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign acc_out   = acc_q;
    assign flags_out = {carry_q, zero_q};
    assign halted    = (state_q == ST_HALT);
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_param_acc_cpu.sv
// Directed bench for param_acc_cpu with an instruction-memory responder and an OUT scoreboard.
// Latency: n/a.
// Backpressure: fetch acks are delayed by 0-5 cycles in the wait-state test.
module tb_param_acc_cpu;

    localparam int DATA_W  = 8;
    localparam int ADDR_W  = 4;
    localparam int INSTR_W = 4 + DATA_W;

    logic               clk;
    logic               reset;
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;
    logic [DATA_W-1:0]  out_data;
    logic               out_valid;
    logic [DATA_W-1:0]  acc_out;
    logic [1:0]         flags_out;
    logic               halted;
    logic               illegal;

    param_acc_cpu #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .acc_out    (acc_out),
        .flags_out  (flags_out),
        .halted     (halted),
        .illegal    (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int pulses = 0;
    int n_out_exp = 0;
    logic [DATA_W-1:0]  exp_q[$];
    int                 fetch_log[$];
    logic [INSTR_W-1:0] mem[16];

    function automatic logic [INSTR_W-1:0] ins(input logic [3:0] op, input logic [7:0] opd);
        return {op, opd};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input logic [DATA_W-1:0] v);
        exp_q.push_back(v);
        n_out_exp++;
    endtask

    // Scoreboard: each out_valid cycle consumes one expected OUT value.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            pulses++;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $error("FAIL out_unexpected observed=%0h expected=none", out_data);
            end else begin
                chk("out_data", out_data, exp_q.pop_front());
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        imem_ack = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        fetch_log.delete();
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 16; i++) mem[i] = '0;
    endtask

    // Serve n fetches; maxd>0 inserts wait states and checks the request is held.
    task automatic run_fetches(input int n, input int maxd);
        for (int k = 0; k < n; k++) begin
            int cyc;
            int d;
            logic [ADDR_W-1:0] a;
            @(negedge clk);
            imem_ack = 1'b0;
            cyc = 0;
            while (imem_req !== 1'b1 && cyc < 50) begin
                @(negedge clk);
                cyc++;
            end
            if (imem_req !== 1'b1) begin
                n_vec++;
                n_err++;
                $error("FAIL fetch_timeout observed=req_low expected=req_high");
                return;
            end
            a = imem_addr;
            fetch_log.push_back(int'(a));
            d = (maxd == 0) ? 0 : ((k == 0) ? 3 : int'($urandom_range(0, maxd)));
            for (int w = 0; w < d; w++) begin
                @(negedge clk);
                chk("wait_req", imem_req, 1);
                chk("wait_addr", imem_addr, a);
            end
            imem_ack   = 1'b1;
            imem_rdata = mem[a];
        end
    endtask

    // Let the last acked instruction execute; ends in the following FETCH (or HALT).
    task automatic settle();
        @(negedge clk);
        imem_ack = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_req"}, imem_req, 1);
        chk({tag, "_addr"}, imem_addr, 0);
        chk({tag, "_acc"}, acc_out, 0);
        chk({tag, "_flags"}, flags_out, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_halted"}, halted, 0);
        chk({tag, "_illegal"}, illegal, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int bad;
        reset      = 1'b1;
        imem_ack   = 1'b0;
        imem_rdata = '0;
        clear_mem();

        // Reset state.
        repeat (2) @(negedge clk);
        check_reset_values("rst");
        reset = 1'b0;

        // LDI F0; ADD 20; OUT -> 0x10 with carry.
        mem[0] = ins(4'h1, 8'hF0);
        mem[1] = ins(4'h2, 8'h20);
        mem[2] = ins(4'hA, 8'h00);
        expect_out(8'h10);
        run_fetches(3, 0);
        settle();
        @(negedge clk);
        chk("add_acc", acc_out, 8'h10);
        chk("add_flags", flags_out, 2'b10);
        chk("add_out_data", out_data, 8'h10);
        chk("add_pulses", pulses, 1);

        // LDI 05; SUB 05; JZ C -> taken.
        do_reset();
        clear_mem();
        mem[0] = ins(4'h1, 8'h05);
        mem[1] = ins(4'h3, 8'h05);
        mem[2] = ins(4'h8, 8'h0C);
        run_fetches(3, 0);
        settle();
        chk("jz_flags", flags_out, 2'b01);
        chk("jz_taken_addr", imem_addr, 4'hC);

        // SUB 04 -> nonzero, JZ falls through.
        do_reset();
        mem[1] = ins(4'h3, 8'h04);
        run_fetches(3, 0);
        settle();
        chk("jz_nt_acc", acc_out, 8'h01);
        chk("jz_nt_addr", imem_addr, 4'h3);

        // LDI 03; SUB 05 -> borrow; JC 9 taken.
        do_reset();
        mem[0] = ins(4'h1, 8'h03);
        mem[1] = ins(4'h3, 8'h05);
        mem[2] = ins(4'h9, 8'h09);
        run_fetches(3, 0);
        settle();
        chk("sub_borrow_acc", acc_out, 8'hFE);
        chk("sub_borrow_flags", flags_out, 2'b10);
        chk("jc_taken_addr", imem_addr, 4'h9);

        // Six-instruction program, zero-wait then random wait states.
        do_reset();
        clear_mem();
        mem[0] = ins(4'h1, 8'h3A);
        mem[1] = ins(4'h2, 8'h0F);
        mem[2] = ins(4'h6, 8'hFF);
        mem[3] = ins(4'h4, 8'h7E);
        mem[4] = ins(4'h5, 8'h81);
        mem[5] = ins(4'hA, 8'h00);
        expect_out(8'hB7);
        run_fetches(6, 0);
        settle();
        chk("prog_acc_nowait", acc_out, 8'hB7);
        chk("prog_flags_nowait", flags_out, 2'b00);
        do_reset();
        expect_out(8'hB7);
        run_fetches(6, 5);
        settle();
        chk("prog_acc_wait", acc_out, 8'hB7);
        chk("prog_flags_wait", flags_out, 2'b00);

        // All-NOP memory: PC wraps 15 -> 0.
        do_reset();
        clear_mem();
        run_fetches(17, 0);
        settle();
        chk("wrap_count", fetch_log.size(), 17);
        for (int i = 0; i < fetch_log.size(); i++) begin
            chk($sformatf("wrap_addr%0d", i), fetch_log[i], i % 16);
        end

        // Undefined opcode B: illegal set, acc untouched.
        do_reset();
        mem[0] = ins(4'h1, 8'h55);
        mem[1] = ins(4'hB, 8'h33);
        mem[2] = ins(4'h0, 8'h00);
        run_fetches(3, 0);
        settle();
        chk("illegal_flag", illegal, 1);
        chk("illegal_acc", acc_out, 8'h55);
        chk("illegal_addr", imem_addr, 4'h3);

        // HLT at address 3: frozen for 20 cycles, stray acks ignored.
        do_reset();
        clear_mem();
        mem[0] = ins(4'h1, 8'h77);
        mem[1] = ins(4'hA, 8'h00);
        mem[2] = ins(4'h0, 8'h00);
        mem[3] = ins(4'hF, 8'h00);
        expect_out(8'h77);
        run_fetches(4, 0);
        settle();
        bad = 0;
        imem_ack   = 1'b1;
        imem_rdata = ins(4'h1, 8'h00);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (imem_req !== 1'b0 || halted !== 1'b1) bad++;
        end
        imem_ack = 1'b0;
        chk("halt_bad_cycles", bad, 0);
        chk("halt_addr", imem_addr, 4'h3);
        chk("halt_acc", acc_out, 8'h77);
        chk("halt_out_data", out_data, 8'h77);
        do_reset();
        check_reset_values("post_halt");

        // Reset coinciding with an ack: instruction discarded.
        clear_mem();
        mem[0] = ins(4'h1, 8'h11);
        mem[1] = ins(4'hA, 8'h00);
        @(negedge clk);
        reset      = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = ins(4'h1, 8'h99);
        @(negedge clk);
        reset    = 1'b0;
        imem_ack = 1'b0;
        @(negedge clk);
        chk("rst_ack_acc", acc_out, 0);
        chk("rst_ack_addr", imem_addr, 0);
        chk("rst_ack_req", imem_req, 1);
        expect_out(8'h11);
        run_fetches(2, 0);
        settle();
        @(negedge clk);
        chk("rst_ack_after_acc", acc_out, 8'h11);

        // Every expected OUT was seen exactly once.
        chk("out_pulse_total", pulses, n_out_exp);
        chk("out_queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
